mlp_eval_sequencer: RTL and testbench

- Sequences one combinational printed-MLP classifier core, e.g. the 4-feature/3-class Iris argmax core.
- Accepts 16-bit feature samples over a valid/ready handshake and holds them on a registered core input.
- Waits a programmable settle time for the slow printed combinational logic, captures the class, optionally re-captures it to detect transient faults, and returns the class plus error flags over a second valid/ready handshake.
- Keeps saturating sample and error counters for fault-injection campaigns.

---
 rtl/mlp_eval_sequencer_if.sv | 26 ++
 rtl/mlp_eval_sequencer.sv | 132 +++++++++++++
 tb/tb_mlp_eval_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_eval_sequencer_if.sv
// mlp_eval_sequencer_if: sample-in / result-out handshake bundle of the MLP sequencer
//   in_valid/in_ready/in_data      : feature sample stream into the sequencer
//   out_valid/out_ready/out_class/out_err : classification result stream out of it
//   master = producer/consumer side, slave = sequencer side
interface mlp_eval_sequencer_if #(
    parameter int IN_W  = 16,
    parameter int CLS_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CLS_W-1:0] out_class;
    logic [1:0]       out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_class, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_class, out_err
    );
endinterface

// File: rtl/mlp_eval_sequencer.sv
// mlp_eval_sequencer: drives a combinational printed-MLP core, waits for it to settle,
//   captures (and optionally re-captures) its class and reports class, error flags and stats.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : sample/result handshakes (slave side)
//   core_inp_o     : registered feature drive to the core
//   core_out_i     : class index coming back from the core
//   busy_o         : sequencer is not idle
//   clr_i          : synchronous clear of the statistics counters
//   sample_cnt_o   : delivered results, saturating
//   err_cnt_o      : delivered results with any error flag, saturating
module mlp_eval_sequencer #(
    parameter int IN_W      = 16,
    parameter int CLS_W     = 2,
    parameter int NUM_CLASS = 3,
    parameter int SETTLE    = 4,
    parameter int RECHECK   = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mlp_eval_sequencer_if.slave bus,
    output logic [IN_W-1:0]  core_inp_o,
    input  logic [CLS_W-1:0] core_out_i,
    output logic             busy_o,
    input  logic             clr_i,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RECHECK, S_OUT} state_t;

    localparam bit         RC_EN      = RECHECK > 0;
    localparam logic [7:0] SETTLE_M1  = 8'(SETTLE - 1);
    localparam logic [7:0] RECHECK_M1 = 8'(RC_EN ? RECHECK - 1 : 0);

    state_t             state_q, state_d;
    logic [7:0]         timer_q, timer_d;
    logic [CLS_W-1:0]   cls_a_q, cls_a_d;
    logic [CLS_W-1:0]   cls_b_q, cls_b_d;
    logic [IN_W-1:0]    core_inp_q, core_inp_d;
    logic [CLS_W-1:0]   out_class_q, out_class_d;
    logic [1:0]         out_err_q, out_err_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               in_ready, accept, out_hs, tmo, enter_out;

    function automatic logic is_illegal(input logic [CLS_W-1:0] c);
        return int'(c) >= NUM_CLASS;
    endfunction

    assign accept = bus.in_valid & in_ready;
    assign out_hs = (state_q == S_OUT) & bus.out_ready;
    assign tmo    = timer_q == 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = accept ? S_SETTLE : S_IDLE;
            S_SETTLE:  state_d = !tmo ? S_SETTLE : (RC_EN ? S_RECHECK : S_OUT);
            S_RECHECK: state_d = tmo ? S_OUT : S_RECHECK;
            S_OUT:     state_d = !out_hs ? S_OUT : (accept ? S_SETTLE : S_IDLE);
            default:   state_d = S_IDLE;
        endcase
    end

    // in_ready looks only at state and out_ready so that a consumer taking the result
    // can let the next sample in on the same edge without a combinational loop on in_valid.
    always_comb begin
        in_ready      = (state_q == S_IDLE) || (state_q == S_OUT && bus.out_ready);
        bus.in_ready  = in_ready;
        bus.out_valid = state_q == S_OUT;
        bus.out_class = out_class_q;
        bus.out_err   = out_err_q;
        busy_o        = state_q != S_IDLE;
        core_inp_o    = core_inp_q;
        sample_cnt_o  = sample_cnt_q;
        err_cnt_o     = err_cnt_q;
    end

    always_comb begin
        timer_d    = timer_q;
        cls_a_d    = cls_a_q;
        cls_b_d    = cls_b_q;
        core_inp_d = core_inp_q;
        if (accept) begin
            core_inp_d = bus.in_data;
            timer_d    = SETTLE_M1;
        end else if (state_q == S_SETTLE) begin
            timer_d = tmo ? RECHECK_M1 : timer_q - 8'd1;
            cls_a_d = tmo ? core_out_i : cls_a_q;
        end else if (state_q == S_RECHECK) begin
            timer_d = tmo ? timer_q : timer_q - 8'd1;
            cls_b_d = tmo ? core_out_i : cls_b_q;
        end
        // result flags are frozen on the edge that enters OUT, from the captures made on that edge
        enter_out    = (state_d == S_OUT) && (state_q != S_OUT);
        out_class_d  = enter_out ? cls_a_d : out_class_q;
        out_err_d    = enter_out ? {RC_EN && (cls_a_d != cls_b_d),
                                    is_illegal(cls_a_d) || (RC_EN && is_illegal(cls_b_d))}
                                 : out_err_q;
        sample_cnt_d = clr_i ? '0
                     : (out_hs && !(&sample_cnt_q)) ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
        err_cnt_d    = clr_i ? '0
                     : (out_hs && out_err_q != 2'b00 && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            cls_a_q      <= '0;
            cls_b_q      <= '0;
            core_inp_q   <= '0;
            out_class_q  <= '0;
            out_err_q    <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            timer_q      <= timer_d;
            cls_a_q      <= cls_a_d;
            cls_b_q      <= cls_b_d;
            core_inp_q   <= core_inp_d;
            out_class_q  <= out_class_d;
            out_err_q    <= out_err_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_mlp_eval_sequencer.sv
// tb_mlp_eval_sequencer: scoreboard bench for mlp_eval_sequencer with a behavioural core model
module tb_mlp_eval_sequencer;
    localparam int S    = 4;
    localparam int R    = 2;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
    localparam int S1   = 3;

    typedef struct {
        logic [1:0] cls;
        logic [1:0] err;
        int         rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlp_eval_sequencer_if #(.IN_W(16), .CLS_W(2)) bi ();
    mlp_eval_sequencer_if #(.IN_W(16), .CLS_W(2)) b1 ();

    logic [15:0]   core_inp, core_inp1;
    logic [1:0]    core_out, core_out1;
    logic          busy, busy1, clr;
    logic [CW-1:0] scnt, ecnt;
    logic [15:0]   scnt1, ecnt1;

    mlp_eval_sequencer #(.SETTLE(S), .RECHECK(R), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bi.slave),
        .core_inp_o(core_inp), .core_out_i(core_out), .busy_o(busy),
        .clr_i(clr), .sample_cnt_o(scnt), .err_cnt_o(ecnt)
    );

    mlp_eval_sequencer #(.SETTLE(S1), .RECHECK(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave),
        .core_inp_o(core_inp1), .core_out_i(core_out1), .busy_o(busy1),
        .clr_i(1'b0), .sample_cnt_o(scnt1), .err_cnt_o(ecnt1)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int age = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: the printed logic shows d[1:0] until the first capture; when d[4] is set
    // it then glitches to d[3:2], which the recheck must catch.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) age <= 0;
        else        age <= (bi.in_valid && bi.in_ready) ? 1 : age + 1;
    assign core_out  = (age <= S) ? core_inp[1:0] : (core_inp[4] ? core_inp[3:2] : core_inp[1:0]);
    assign core_out1 = core_inp1[1:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
    endtask

    function automatic exp_t predict(input logic [15:0] d, input int rise);
        exp_t e;
        logic [1:0] a, b;
        a = d[1:0];
        b = d[4] ? d[3:2] : d[1:0];
        e.cls  = a;
        e.err  = {a != b, (a >= 2'd3) || (b >= 2'd3)};
        e.rise = rise;
        return e;
    endfunction

    // Monitor: counters, hold-under-backpressure, latency and result checks.
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [1:0]  prev_cls = '0;
    logic [15:0] prev_inp = '0;
    int m_s = 0, m_e = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_s = 0;
            m_e = 0;
            prev_v = 1'b0;
        end else begin
            check("sample_cnt", 32'(scnt), m_s);
            check("err_cnt", 32'(ecnt), m_e);
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(bi.out_valid), 1);
                check("hold_class", 32'(bi.out_class), 32'(prev_cls));
                check("hold_core_inp", 32'(core_inp), 32'(prev_inp));
            end
            if (bi.out_valid && !prev_v) begin
                if (sb.size() == 0) fail("spurious_out_valid");
                else check("latency", cyc, sb[0].rise);
            end
            if (bi.out_valid && bi.out_ready && sb.size() > 0) begin
                check("out_class", 32'(bi.out_class), 32'(sb[0].cls));
                check("out_err", 32'(bi.out_err), 32'(sb[0].err));
                if (clr) begin
                    m_s = 0;
                    m_e = 0;
                end else begin
                    m_s = (m_s == MAXC) ? m_s : m_s + 1;
                    if (sb[0].err != 2'b00) m_e = (m_e == MAXC) ? m_e : m_e + 1;
                end
                void'(sb.pop_front());
            end else if (clr) begin
                m_s = 0;
                m_e = 0;
            end
            prev_v   = bi.out_valid;
            prev_r   = bi.out_ready;
            prev_cls = bi.out_class;
            prev_inp = core_inp;
        end
    end

    logic        acc_pend = 1'b0;
    logic [15:0] acc_d = '0;

    task automatic step(input logic v, input logic [15:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        if (acc_pend) begin
            check("core_inp_load", 32'(core_inp), 32'(acc_d));
            acc_pend = 1'b0;
        end
        bi.in_valid  = v;
        bi.in_data   = d;
        bi.out_ready = r;
        clr          = c;
        @(negedge clk);
        if (bi.in_valid && bi.in_ready) begin
            sb.push_back(predict(d, cyc + 1 + S + R));
            acc_pend = 1'b1;
            acc_d    = d;
        end
    endtask

    int c1 = 0;
    task automatic run1(input logic [15:0] d, input logic [1:0] ecls, input logic [1:0] eerr);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        b1.in_valid = 1'b1;
        b1.in_data = d;
        b1.out_ready = 1'b0;
        @(negedge clk);
        check("u1_in_ready", 32'(b1.in_ready), 1);
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
        check("u1_core_inp", 32'(core_inp1), 32'(d));
        while (!b1.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("u1_latency", n, S1);
        check("u1_class", 32'(b1.out_class), 32'(ecls));
        check("u1_err", 32'(b1.out_err), 32'(eerr));
        b1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b1.out_ready = 1'b0;
        c1++;
        check("u1_valid_drop", 32'(b1.out_valid), 0);
        check("u1_sample_cnt", 32'(scnt1), c1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bi.in_valid = 1'b0; bi.in_data = '0; bi.out_ready = 1'b0; clr = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bi.in_ready), 1);
        check("rst_out_valid", 32'(bi.out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_core_inp", 32'(core_inp), 0);
        check("rst_sample_cnt", 32'(scnt), 0);
        check("rst_err_cnt", 32'(ecnt), 0);
        // clean, glitching and illegal-class samples
        step(1'b1, 16'h1235, 1'b1, 1'b0);
        repeat (10) step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h0018, 1'b1, 1'b0);
        repeat (10) step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h0003, 1'b1, 1'b0);
        repeat (10) step(1'b0, 16'h0000, 1'b1, 1'b0);
        // long backpressure with a sample waiting, then consume and load on one edge
        step(1'b1, 16'h0021, 1'b0, 1'b0);
        repeat (28) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'h0036, 1'b1, 1'b0);
        // random traffic; clears land mid-run and late (saturation in between)
        for (int i = 0; i < 400; i++)
            step($urandom % 4 != 0, 16'($urandom), $urandom % 5 != 0, i == 60 || i == 330);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        // RECHECK=0 build: illegal class flagged, never a mismatch
        run1(16'h0003, 2'd3, 2'b01);
        run1(16'h0019, 2'd1, 2'b00);
        run1(16'h00f2, 2'd2, 2'b00);
        // asynchronous reset while the main sequencer is in its recheck window
        step(1'b1, 16'h0015, 1'b1, 1'b0);
        repeat (S + 1) step(1'b0, 16'h0000, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bi.out_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_core_inp", 32'(core_inp), 0);
        check("arst_out_class", 32'(bi.out_class), 0);
        check("arst_out_err", 32'(bi.out_err), 0);
        check("arst_sample_cnt", 32'(scnt), 0);
        check("arst_err_cnt", 32'(ecnt), 0);
        sb.delete();
        acc_pend = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (12) step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_in_ready", 32'(bi.in_ready), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
